// File: rtl/dspl_pkg.sv
// Shared definitions for the 8-digit display frame writer.
// - Character codes understood by the display multiplexer.
// - dig_entry_t: one staged/displayed digit {en, ch, dp, blink}.
// - to_dspl_code(): packs an entry into the 7-bit driver code
//   {enable, char[4:0], dp_n}, applying the blink phase.
package dspl_pkg;

  localparam int NUM_DIG = 8;

  localparam logic [4:0] CH_0     = 5'h00;
  localparam logic [4:0] CH_1     = 5'h01;
  localparam logic [4:0] CH_2     = 5'h02;
  localparam logic [4:0] CH_3     = 5'h03;
  localparam logic [4:0] CH_4     = 5'h04;
  localparam logic [4:0] CH_J     = 5'h05;
  localparam logic [4:0] CH_S     = 5'h06;
  localparam logic [4:0] CH_E     = 5'h07;
  localparam logic [4:0] CH_T     = 5'h08;
  localparam logic [4:0] CH_U     = 5'h09;
  localparam logic [4:0] CH_P     = 5'h0A;
  localparam logic [4:0] CH_B     = 5'h0B;
  localparam logic [4:0] CH_C     = 5'h0C;
  localparam logic [4:0] CH_L     = 5'h0D;
  localparam logic [4:0] CH_Y     = 5'h0E;
  localparam logic [4:0] CH_G     = 5'h0F;
  localparam logic [4:0] CH_BLANK = 5'h10;
  localparam logic [4:0] CH_DASH  = 5'h11;

  typedef struct packed {
    logic       en;
    logic [4:0] ch;
    logic       dp;
    logic       blink;
  } dig_entry_t;

  // Blank, unlit, non-blinking digit; also what CLEAR writes.
  localparam dig_entry_t ENTRY_RST = '{en: 1'b0, ch: CH_BLANK, dp: 1'b0, blink: 1'b0};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fsm_state_t;

  // Codes above the dash have no glyph; show them as blank.
  function automatic logic [4:0] legal_char(input logic [4:0] c);
    return (c > CH_DASH) ? CH_BLANK : c;
  endfunction

  // Hidden blink phase only drops the enable bit; char and dp stay put.
  function automatic logic [6:0] to_dspl_code(input dig_entry_t e, input logic phase);
    return {e.en & ~(e.blink & phase), e.ch, ~e.dp};
  endfunction

endpackage

// File: rtl/dspl_frame_writer_if.sv
// Game-logic side port of the frame writer.
// - wr_*      : valid/ready character write into the staging buffer
// - clear     : blank the whole staging buffer (takes 8 cycles)
// - commit    : copy staging buffer to the displayed frame
// - committed : one-cycle pulse after a frame has been applied
// master = game logic, slave = frame writer.
interface dspl_frame_writer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_pos;
  logic [4:0] wr_char;
  logic       wr_dp;
  logic       wr_blink;
  logic       clear;
  logic       commit;
  logic       committed;

  modport master (
    output wr_valid, wr_pos, wr_char, wr_dp, wr_blink, clear, commit,
    input  wr_ready, committed
  );

  modport slave (
    input  wr_valid, wr_pos, wr_char, wr_dp, wr_blink, clear, commit,
    output wr_ready, committed
  );
endinterface

// File: rtl/dspl_blink_timer.sv
// Free-running blink phase generator.
// - clock, reset : system clock, async active-low reset
// - restart      : synchronous restart (counter=0, phase=0 -> visible)
// - phase        : 0 = visible half, 1 = hidden half; toggles every
//                  BLINK_HALF_COUNT cycles
module dspl_blink_timer #(
  parameter int BLINK_HALF_COUNT = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic phase
);

  localparam int CW = (BLINK_HALF_COUNT > 1) ? $clog2(BLINK_HALF_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF_COUNT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      count <= '0;
      phase <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dspl_frame_writer.sv
// Producer side of the 8-digit display: staging buffer + atomic commit.
// - clock, reset : system clock, async active-low reset
// - wr           : write/clear/commit port (slave side)
// - d1..d8       : 7-bit digit codes {en, char[4:0], dp_n}, d1 = rightmost
// Writes land in the staging buffer only; the displayed (front) frame
// changes solely on an applied commit or a blink phase toggle, so the
// display never shows a half-written frame.
module dspl_frame_writer
  import dspl_pkg::*;
#(
  parameter int BLINK_HALF_COUNT = 25_000_000
) (
  input  logic                clock,
  input  logic                reset,
  dspl_frame_writer_if.slave  wr,
  output logic [6:0]          d1,
  output logic [6:0]          d2,
  output logic [6:0]          d3,
  output logic [6:0]          d4,
  output logic [6:0]          d5,
  output logic [6:0]          d6,
  output logic [6:0]          d7,
  output logic [6:0]          d8
);

  fsm_state_t                  state;
  logic [2:0]                  ptr;
  logic                        commit_pend;
  logic                        committed_q;
  dig_entry_t [NUM_DIG-1:0]    staging, staging_nxt, front;
  logic [NUM_DIG-1:0][6:0]     dcode;
  logic                        accept, apply, phase;
  dig_entry_t                  new_entry;

  assign wr.wr_ready  = (state == IDLE) & ~wr.clear;
  assign wr.committed = committed_q;
  assign accept       = wr.wr_valid & wr.wr_ready;

  // A pending commit (raised while clearing) fires on the first IDLE edge,
  // i.e. only once the buffer is fully blanked.
  assign apply = (state == IDLE) & ~wr.clear & (wr.commit | commit_pend);

  always_comb begin
    new_entry       = ENTRY_RST;
    new_entry.en    = 1'b1;
    new_entry.ch    = legal_char(wr.wr_char);
    new_entry.dp    = wr.wr_dp;
    new_entry.blink = wr.wr_blink;
  end

  // Next staging contents; also the commit source so a write accepted in
  // the commit cycle is included.
  always_comb begin
    staging_nxt = staging;
    if (accept)
      staging_nxt[wr.wr_pos] = new_entry;
    if (state == CLEAR)
      staging_nxt[ptr] = ENTRY_RST;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      commit_pend <= 1'b0;
      committed_q <= 1'b0;
      staging     <= {NUM_DIG{ENTRY_RST}};
      front       <= {NUM_DIG{ENTRY_RST}};
    end else begin
      staging     <= staging_nxt;
      committed_q <= apply;
      if (apply)
        front <= staging_nxt;

      // Commits arriving with clear or during CLEAR collapse into one.
      if (apply)
        commit_pend <= 1'b0;
      else if (wr.commit)
        commit_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (wr.clear) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          ptr <= ptr + 3'd1;
          if (ptr == 3'd7)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dspl_blink_timer #(
    .BLINK_HALF_COUNT(BLINK_HALF_COUNT)
  ) u_blink (
    .clock   (clock),
    .reset   (reset),
    .restart (apply),
    .phase   (phase)
  );

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    assign dcode[g] = to_dspl_code(front[g], phase);
  end

  assign d1 = dcode[0];
  assign d2 = dcode[1];
  assign d3 = dcode[2];
  assign d4 = dcode[3];
  assign d5 = dcode[4];
  assign d6 = dcode[5];
  assign d7 = dcode[6];
  assign d8 = dcode[7];

endmodule

// File: tb/tb_dspl_frame_writer.sv
// Scoreboard bench: expected frames are queued before each commit; the
// monitor pops and compares on every committed pulse. Timing/blink/clear
// behaviour is checked directly by the stimulus process.
module tb_dspl_frame_writer;

  localparam logic [6:0] B = 7'h21;  // reset/blank digit code

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [6:0] d1, d2, d3, d4, d5, d6, d7, d8;

  int total = 0;
  int bad   = 0;
  logic [55:0] exp_q[$];

  dspl_frame_writer_if bus();

  dspl_frame_writer #(.BLINK_HALF_COUNT(4)) dut (
    .clock (clock),
    .reset (reset),
    .wr    (bus),
    .d1    (d1), .d2(d2), .d3(d3), .d4(d4),
    .d5    (d5), .d6(d6), .d7(d7), .d8(d8)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] frame();
    return {d8, d7, d6, d5, d4, d3, d2, d1};
  endfunction

  // Monitor: every committed pulse must match the next queued frame.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && bus.committed === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", 64'd1, 64'd0);
        end else begin
          chk("commit_frame", {8'h0, frame()}, {8'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_char(input logic [2:0] pos, input logic [4:0] ch,
                         input logic dp, input logic bl, input logic cm);
    bus.wr_valid = 1'b1;
    bus.wr_pos   = pos;
    bus.wr_char  = ch;
    bus.wr_dp    = dp;
    bus.wr_blink = bl;
    bus.commit   = cm;
    tick();
    bus.wr_valid = 1'b0;
    bus.commit   = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_pos   = '0;
    bus.wr_char  = '0;
    bus.wr_dp    = 1'b0;
    bus.wr_blink = 1'b0;
    bus.clear    = 1'b0;
    bus.commit   = 1'b0;

    // 1. reset state
    #23;
    chk("rst_frame", {8'h0, frame()}, {8'h0, {8{B}}});
    chk("rst_committed", {63'h0, bus.committed}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("rst_ready", {63'h0, bus.wr_ready}, 64'd1);

    // 2. write then commit
    wr_char(3'd0, 5'h03, 1'b1, 1'b0, 1'b0);
    wr_char(3'd7, 5'h11, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({7'h63, B, B, B, B, B, B, 7'h46});
    do_commit();
    @(negedge clock);
    chk("t2_pulse", {63'h0, bus.committed}, 64'd1);
    @(negedge clock);
    chk("t2_pulse_end", {63'h0, bus.committed}, 64'd0);
    tick();

    // 3. atomicity: write alone is invisible, write+commit is visible
    wr_char(3'd1, 5'h05, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("t3_no_commit", {8'h0, frame()}, {8'h0, 7'h63, B, B, B, B, B, B, 7'h46});
    tick();
    exp_q.push_back({7'h63, B, B, B, B, 7'h51, 7'h4B, 7'h46});
    wr_char(3'd2, 5'h08, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    chk("t3_bypass_pulse", {63'h0, bus.committed}, 64'd1);
    tick();

    // 4. clear timing with commit during CLEAR cycle 3
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    exp_q.push_back({8{B}});
    for (int i = 1; i <= 8; i++) begin
      bus.commit = (i == 3);
      @(negedge clock);
      chk("t4_ready_low", {63'h0, bus.wr_ready}, 64'd0);
      chk("t4_no_pulse", {63'h0, bus.committed}, 64'd0);
      if (i == 8)
        chk("t4_frame_held", {8'h0, frame()}, {8'h0, 7'h63, B, B, B, B, 7'h51, 7'h4B, 7'h46});
      tick();
    end
    bus.commit = 1'b0;
    @(negedge clock);
    chk("t4_ready_back", {63'h0, bus.wr_ready}, 64'd1);
    chk("t4_pulse_wait", {63'h0, bus.committed}, 64'd0);
    tick();
    @(negedge clock);
    chk("t4_pend_pulse", {63'h0, bus.committed}, 64'd1);
    tick();

    // 5. blink: 4 visible, 4 hidden, 4 visible
    wr_char(3'd2, 5'h07, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({B, B, B, B, B, 7'h4F, B, B});
    do_commit();
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk("t5_d3", {57'h0, d3}, (((k / 4) % 2) == 0) ? 64'h4F : 64'h0F);
      chk("t5_d1", {57'h0, d1}, {57'h0, B});
    end
    tick();

    // 6. illegal char stored as blank; commit restarts blink visible
    exp_q.push_back({B, B, B, 7'h61, B, 7'h4F, B, B});
    wr_char(3'd4, 5'h1F, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    chk("t6_pulse", {63'h0, bus.committed}, 64'd1);
    tick();

    // reset dropped mid-CLEAR with a pending commit
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rst_frame", {8'h0, frame()}, {8'h0, {8{B}}});
    chk("t6_rst_committed", {63'h0, bus.committed}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk("t6_no_pulse", {63'h0, bus.committed}, 64'd0);
    end
    chk("t6_frame_after", {8'h0, frame()}, {8'h0, {8{B}}});
    chk("t6_ready_after", {63'h0, bus.wr_ready}, 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
